// File: rtl/waveform_capture_pkg.sv
// -----------------------------------------------------------------------------
// waveform_capture_pkg
// Constants shared by the waveform write side and the display reader: the
// circular buffer geometry, the sample width, the capture state encoding,
// and a small unsigned-max helper.
// -----------------------------------------------------------------------------
package waveform_capture_pkg;

  // Circular waveform buffer: one stored sample per screen column.
  localparam int WF_DEPTH  = 1024;
  localparam int WF_ADDR_W = 10;

  // Heart-signal sample width.
  localparam int SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Capture state encoding. The display side decodes these same values.
  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  // Unsigned peak of two samples.
  function automatic sample_t max_u8(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/waveform_capture_peak_decimator.sv
// -----------------------------------------------------------------------------
// waveform_capture_peak_decimator
// Peak-decimates the sample stream: every DECIMATE accepted samples produce
// one commit carrying the largest value seen in that window.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   i_en           accept samples this cycle (capture not frozen)
//   i_clear        discard the partial window on this edge
//   i_sample_valid one-cycle sample strobe
//   i_sample_in    unsigned sample value
//   o_commit       this cycle's strobe completes a window (combinational)
//   o_commit_data  peak of the completed window (valid with o_commit)
// -----------------------------------------------------------------------------
module waveform_capture_peak_decimator
  import waveform_capture_pkg::*;
#(
  parameter int DECIMATE = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    i_en,
  input  logic    i_clear,
  input  logic    i_sample_valid,
  input  sample_t i_sample_in,
  output logic    o_commit,
  output sample_t o_commit_data
);

  // Index of the last sample in a window. The counter never passes it, so an
  // equality test is enough; with DECIMATE=1 every strobe commits.
  localparam logic [7:0] LAST_IDX = 8'(DECIMATE - 1);

  logic [7:0] r_dec_cnt;
  sample_t    r_acc;

  logic    w_take;
  logic    w_more;
  sample_t w_peak;

  assign w_take = i_en & i_sample_valid;
  assign w_more = (r_dec_cnt != LAST_IDX);
  assign w_peak = max_u8(r_acc, i_sample_in);

  // The commit is reported in the strobe cycle itself; the top registers it,
  // which gives the one-cycle write latency. It does not depend on i_clear,
  // so a window completing as freeze arrives is still written.
  assign o_commit      = w_take & ~w_more;
  assign o_commit_data = w_peak;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dec_cnt <= '0;
      r_acc     <= '0;
    end else if (i_clear) begin
      r_dec_cnt <= '0;
      r_acc     <= '0;
    end else if (w_take) begin
      if (w_more) begin
        r_acc     <= w_peak;
        r_dec_cnt <= r_dec_cnt + 8'd1;
      end else begin
        r_acc     <= '0;
        r_dec_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/waveform_capture.sv
// -----------------------------------------------------------------------------
// waveform_capture
// Write side of the scrolling waveform display. Peak-decimates the incoming
// sample stream, writes decimated samples into a circular dual-port BRAM and,
// at each frame start, publishes the oldest-sample address so the reader
// fetches column hcount at (frame_base_adr + hcount) mod DEPTH without tearing.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   sample_in      unsigned sample value
//   sample_valid   one-cycle sample strobe
//   freeze         level; high stops writing and holds the buffer
//   vsync          VGA frame sync; rising edge is the frame boundary
//   bram_we        single-cycle BRAM write enable
//   bram_wr_adr    BRAM write address
//   bram_wr_data   BRAM write data
//   frame_base_adr oldest-sample address, stable for the whole frame
//   fill_level     samples stored, saturating at DEPTH
//   wrapped        buffer has filled at least once
//   frozen         capture is in the FROZEN state
// -----------------------------------------------------------------------------
module waveform_capture
  import waveform_capture_pkg::*;
#(
  parameter int DEPTH    = WF_DEPTH,
  parameter int ADDR_W   = WF_ADDR_W,
  parameter int DECIMATE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              freeze,
  input  logic              vsync,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_wr_adr,
  output logic [SAMPLE_W-1:0] bram_wr_data,
  output logic [ADDR_W-1:0] frame_base_adr,
  output logic [ADDR_W:0]   fill_level,
  output logic              wrapped,
  output logic              frozen
);

  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W + 1)'(DEPTH);

  logic [1:0]          r_state;
  logic                r_frozen;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W:0]     r_fill_level;
  logic                r_wrapped;
  logic                r_vsync_d;
  logic [ADDR_W-1:0]   r_frame_base;
  logic                r_bram_we;
  logic [ADDR_W-1:0]   r_bram_adr;
  sample_t             r_bram_data;

  logic       w_active;
  logic       w_clear;
  logic       w_commit;
  sample_t    w_commit_data;
  logic       w_wrap_hit;
  logic       w_vsync_rise;
  logic [1:0] w_state_nxt;

  // Samples are accepted in FILL and RUN. The partial window is dropped on
  // the edge freeze is first seen and held empty for the whole freeze.
  assign w_active = (r_state != ST_FROZEN);
  assign w_clear  = ~w_active | freeze;

  waveform_capture_peak_decimator #(
    .DECIMATE (DECIMATE)
  ) u_peak_decimator (
    .clk            (clk),
    .reset          (reset),
    .i_en           (w_active),
    .i_clear        (w_clear),
    .i_sample_valid (sample_valid),
    .i_sample_in    (sample_in),
    .o_commit       (w_commit),
    .o_commit_data  (w_commit_data)
  );

  // The write landing on the last address is what first fills the buffer.
  assign w_wrap_hit   = w_commit & (r_wr_ptr == LAST_ADR);
  assign w_vsync_rise = vsync & ~r_vsync_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: begin
        if (freeze)          w_state_nxt = ST_FROZEN;
        else if (w_wrap_hit) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (freeze) w_state_nxt = ST_FROZEN;
      end
      ST_FROZEN: begin
        // No write can land while frozen, so r_wrapped is already current.
        if (!freeze) w_state_nxt = r_wrapped ? ST_RUN : ST_FILL;
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_FILL;
      r_frozen <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_frozen <= (w_state_nxt == ST_FROZEN);
    end
  end

  // Write port: the commit strobe becomes a one-cycle pulse at the old
  // pointer while the pointer advances on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bram_we    <= 1'b0;
      r_bram_adr   <= '0;
      r_bram_data  <= '0;
      r_wr_ptr     <= '0;
      r_fill_level <= '0;
      r_wrapped    <= 1'b0;
    end else begin
      r_bram_we <= w_commit;
      if (w_commit) begin
        r_bram_adr  <= r_wr_ptr;
        r_bram_data <= w_commit_data;
        r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
        if (r_fill_level != FULL_LVL) begin
          r_fill_level <= r_fill_level + (ADDR_W + 1)'(1);
        end
        if (w_wrap_hit) begin
          r_wrapped <= 1'b1;
        end
      end
    end
  end

  // Frame base: sampled from the pre-increment pointer, so a write on the
  // same edge only shows up in the next frame. Before the first wrap the
  // oldest sample is always at address 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsync_d    <= 1'b0;
      r_frame_base <= '0;
    end else begin
      r_vsync_d <= vsync;
      if (w_vsync_rise) begin
        r_frame_base <= r_wrapped ? r_wr_ptr : '0;
      end
    end
  end

  assign bram_we        = r_bram_we;
  assign bram_wr_adr    = r_bram_adr;
  assign bram_wr_data   = r_bram_data;
  assign frame_base_adr = r_frame_base;
  assign fill_level     = r_fill_level;
  assign wrapped        = r_wrapped;
  assign frozen         = r_frozen;

endmodule

// File: tb/tb_waveform_capture.sv
// -----------------------------------------------------------------------------
// tb_waveform_capture
// Two instances share one stimulus stream: A (DEPTH=16, DECIMATE=4) and
// B (DEPTH=8, DECIMATE=1). A behavioural model keeps each window as a plain
// list of samples and takes its maximum when the list is full; a compare
// process checks both instances every cycle. Directed scenarios add literal
// expectations, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_waveform_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       freeze;
  logic       vsync;

  always #5 clk = ~clk;

  logic       a_we, a_wrapped, a_frozen;
  logic [3:0] a_adr, a_base;
  logic [7:0] a_data;
  logic [4:0] a_fill;

  logic       b_we, b_wrapped, b_frozen;
  logic [2:0] b_adr, b_base;
  logic [7:0] b_data;
  logic [3:0] b_fill;

  waveform_capture #(.DEPTH(16), .ADDR_W(4), .DECIMATE(4)) u_dut_a (
    .clk            (clk),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .freeze         (freeze),
    .vsync          (vsync),
    .bram_we        (a_we),
    .bram_wr_adr    (a_adr),
    .bram_wr_data   (a_data),
    .frame_base_adr (a_base),
    .fill_level     (a_fill),
    .wrapped        (a_wrapped),
    .frozen         (a_frozen)
  );

  waveform_capture #(.DEPTH(8), .ADDR_W(3), .DECIMATE(1)) u_dut_b (
    .clk            (clk),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .freeze         (freeze),
    .vsync          (vsync),
    .bram_we        (b_we),
    .bram_wr_adr    (b_adr),
    .bram_wr_data   (b_data),
    .frame_base_adr (b_base),
    .fill_level     (b_fill),
    .wrapped        (b_wrapped),
    .frozen         (b_frozen)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ptr[2], m_fill[2], m_base[2], m_we[2], m_adr[2], m_data[2], m_wlen[2];
  int m_win[2][256];
  bit m_wrapped[2], m_frozen[2];
  bit m_vprev;

  function automatic int depth_of(input int k);
    return (k == 0) ? 16 : 8;
  endfunction

  function automatic int dec_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_fill[k] = 0; m_base[k] = 0; m_we[k] = 0;
      m_adr[k] = 0; m_data[k] = 0; m_wlen[k] = 0;
      m_wrapped[k] = 1'b0; m_frozen[k] = 1'b0;
    end
    m_vprev = 1'b0;
  endtask

  task automatic model_step();
    bit rise;
    int pk;
    rise    = vsync && !m_vprev;
    m_vprev = vsync;
    for (int k = 0; k < 2; k++) begin
      m_we[k] = 0;
      if (rise) m_base[k] = m_wrapped[k] ? m_ptr[k] : 0;
      if (!m_frozen[k]) begin
        if (sample_valid) begin
          m_win[k][m_wlen[k]] = int'(sample_in);
          m_wlen[k]++;
          if (m_wlen[k] == dec_of(k)) begin
            pk = 0;
            for (int i = 0; i < m_wlen[k]; i++)
              if (m_win[k][i] > pk) pk = m_win[k][i];
            m_we[k]   = 1;
            m_adr[k]  = m_ptr[k];
            m_data[k] = pk;
            if (m_ptr[k] == depth_of(k) - 1) m_wrapped[k] = 1'b1;
            m_ptr[k] = (m_ptr[k] + 1) % depth_of(k);
            if (m_fill[k] < depth_of(k)) m_fill[k]++;
            m_wlen[k] = 0;
          end
        end
        if (freeze) begin
          m_frozen[k] = 1'b1;
          m_wlen[k]   = 0;
        end
      end else if (!freeze) begin
        m_frozen[k] = 1'b0;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp(input int k, input int we, input int adr, input int data,
                     input int base, input int fill, input int wr, input int fz);
    check($sformatf("dut%0d.bram_we", k), we, m_we[k]);
    if (m_we[k] != 0) begin
      check($sformatf("dut%0d.bram_wr_adr", k), adr, m_adr[k]);
      check($sformatf("dut%0d.bram_wr_data", k), data, m_data[k]);
    end
    check($sformatf("dut%0d.frame_base_adr", k), base, m_base[k]);
    check($sformatf("dut%0d.fill_level", k), fill, m_fill[k]);
    check($sformatf("dut%0d.wrapped", k), wr, int'(m_wrapped[k]));
    check($sformatf("dut%0d.frozen", k), fz, int'(m_frozen[k]));
  endtask

  always @(negedge clk) begin
    cmp(0, int'(a_we), int'(a_adr), int'(a_data), int'(a_base), int'(a_fill),
        int'(a_wrapped), int'(a_frozen));
    cmp(1, int'(b_we), int'(b_adr), int'(b_data), int'(b_base), int'(b_fill),
        int'(b_wrapped), int'(b_frozen));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input int s, input bit f, input bit vs);
    sample_valid = v;
    sample_in    = 8'(s);
    freeze       = f;
    vsync        = vs;
    @(negedge clk);
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    freeze       = 1'b0;
    vsync        = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit frz;
    bit vs;
    int vals[4];

    sample_valid = 1'b0;
    sample_in    = '0;
    freeze       = 1'b0;
    vsync        = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset.bram_we", int'(a_we), 0);
    check("reset.fill_level", int'(a_fill), 0);
    check("reset.frame_base", int'(a_base), 0);
    check("reset.wrapped", int'(a_wrapped), 0);
    check("reset.frozen", int'(a_frozen), 0);
    reset = 1'b0;

    // One window of four: peak 50 written at address 0.
    vals = '{10, 50, 20, 30};
    for (int i = 0; i < 4; i++) cyc(1'b1, vals[i], 1'b0, 1'b0);
    check("win4.we", int'(a_we), 1);
    check("win4.adr", int'(a_adr), 0);
    check("win4.data", int'(a_data), 50);
    check("win4.fill", int'(a_fill), 1);
    check("pass1.adr", int'(b_adr), 3);
    check("pass1.data", int'(b_data), 30);
    check("pass1.fill", int'(b_fill), 4);
    cyc(1'b0, 0, 1'b0, 1'b0);
    check("win4.we_after", int'(a_we), 0);

    // Before wrap the frame base stays 0.
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, i, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1);
    check("prewrap.base", int'(b_base), 0);
    cyc(1'b0, 0, 1'b0, 1'b0);

    // DEPTH=8, pass-through: wrap, saturation and base after wrap.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, i, 1'b0, 1'b0);
      if (i == 6) check("wrap.before", int'(b_wrapped), 0);
      if (i == 7) begin
        check("wrap.adr7", int'(b_adr), 7);
        check("wrap.set", int'(b_wrapped), 1);
      end
    end
    check("wrap.adr_last", int'(b_adr), 1);
    check("wrap.fill_sat", int'(b_fill), 8);
    cyc(1'b0, 0, 1'b0, 1'b1);
    check("wrap.base", int'(b_base), 2);
    cyc(1'b0, 0, 1'b0, 1'b0);

    // Freeze discards the partial window and blocks writes.
    do_reset();
    cyc(1'b1, 200, 1'b0, 1'b0);
    cyc(1'b1, 100, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    check("frz.frozen", int'(a_frozen), 1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 250, 1'b1, 1'b0);
    check("frz.fill", int'(a_fill), 0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    check("frz.released", int'(a_frozen), 0);
    for (int i = 5; i <= 8; i++) cyc(1'b1, i, 1'b0, 1'b0);
    check("frz.we", int'(a_we), 1);
    check("frz.data", int'(a_data), 8);
    check("frz.adr", int'(a_adr), 0);

    // Commit strobed in the cycle freeze is first seen is still written.
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(1'b1, i, 1'b0, 1'b0);
    cyc(1'b1, 4, 1'b1, 1'b0);
    check("frzc.we", int'(a_we), 1);
    check("frzc.data", int'(a_data), 4);
    check("frzc.frozen", int'(a_frozen), 1);
    cyc(1'b0, 0, 1'b0, 1'b0);

    // vsync rise coincident with a write latches the pre-increment pointer.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, i, 1'b0, 1'b0);
    cyc(1'b1, 9, 1'b0, 1'b1);
    check("vsw.base", int'(b_base), 1);
    check("vsw.adr", int'(b_adr), 1);
    cyc(1'b1, 10, 1'b0, 1'b1);
    cyc(1'b1, 11, 1'b0, 1'b1);
    check("vsw.base_hold", int'(b_base), 1);
    cyc(1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1);
    check("vsw.base_next", int'(b_base), 4);
    cyc(1'b0, 0, 1'b0, 1'b0);

    // Reset during the write-pulse cycle aborts the write.
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, i, 1'b0, 1'b0);
    check("rstw.pulse", int'(a_we), 1);
    #1 reset = 1'b1;
    #1;
    check("rstw.we", int'(a_we), 0);
    check("rstw.adr", int'(a_adr), 0);
    check("rstw.data", int'(a_data), 0);
    check("rstw.fill", int'(a_fill), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 9, 1'b0, 1'b0);
    check("rstw.first_adr", int'(a_adr), 0);
    check("rstw.first_we", int'(a_we), 1);

    // Randomized phase.
    do_reset();
    frz = 1'b0;
    vs  = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 79) == 0) frz = ~frz;
      if ($urandom_range(0, 24) == 0) vs = ~vs;
      cyc($urandom_range(0, 99) < 60, int'($urandom_range(0, 255)), frz, vs);
      if ($urandom_range(0, 1499) == 0) begin
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/waveform_capture.md
Name: waveform_capture

Overview:
- Write-side companion to the scrolling waveform display.
- Accepts the 8-bit heart-signal sample stream and peak-decimates it.
- Writes decimated samples into the write port of a dual-port circular BRAM.
- At each frame start, publishes a stable base address. The display reader fetches column hcount at (frame_base_adr + hcount) mod DEPTH, so the trace scrolls with no tearing.

Parameters:
- DEPTH, 1024, circular buffer length in samples (one per screen column); power of two.
- ADDR_W, 10, log2(DEPTH).
- DECIMATE, 4, input samples per stored sample; range 1..255; 1 = pass-through.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_in  in  8  unsigned sample value.
- sample_valid  in  1  one-cycle strobe; sample_in is valid in that cycle.
- freeze  in  1  level; high = stop writing and hold buffer contents.
- vsync  in  1  frame sync from VGA timing; the rising edge marks the frame boundary.
- bram_we  out  1  BRAM write enable, single-cycle pulse.
- bram_wr_adr  out  ADDR_W  BRAM write address.
- bram_wr_data  out  8  BRAM write data.
- frame_base_adr  out  ADDR_W  oldest-sample address, valid for the whole frame.
- fill_level  out  ADDR_W+1  samples stored; saturates at DEPTH.
- wrapped  out  1  buffer has filled at least once.
- frozen  out  1  high while in FROZEN.

Behaviour:
- All outputs and internal state are registered. Reset clears everything to 0, including wr_ptr, dec_cnt, acc (running max) and the vsync delay flop; state resets to FILL. Reset asserted mid-write aborts that write: bram_we is 0 while reset is high.
- States:
  - FILL: wrapped=0.
  - RUN: wrapped=1.
  - FROZEN.
- Transitions:
  - FILL->RUN when a write lands at address DEPTH-1.
  - FILL/RUN->FROZEN when freeze=1 is sampled.
  - FROZEN->(wrapped ? RUN : FILL) when freeze=0 is sampled.
- Decimation (FILL/RUN only), on a cycle with sample_valid=1:
  - If dec_cnt < DECIMATE-1: acc <= max(acc, sample_in); dec_cnt++.
  - Else: commit max(acc, sample_in); acc <= 0; dec_cnt <= 0.
- Commit timing and write pulse:
  - Commit latency is one cycle. In the cycle after the commit strobe, bram_we=1, bram_wr_adr=wr_ptr(old), bram_wr_data=committed value.
  - On that same edge, wr_ptr <= wr_ptr+1 mod DEPTH (DEPTH-1 -> 0).
  - bram_we is 0 in all other cycles.
- fill_level increments on each write and saturates at DEPTH. wrapped is set on the write to DEPTH-1 and cleared only by reset.
- Freeze:
  - While frozen=1, sample_valid is ignored and dec_cnt and acc are held at 0. Any partial decimation window is discarded when FROZEN is entered.
  - A commit strobed in the same cycle freeze is first sampled still produces its write pulse on the next cycle; it is never lost.
  - Leaving FROZEN starts a fresh decimation window.
- Frame base:
  - vsync_d <= vsync. On vsync & ~vsync_d, frame_base_adr <= wrapped ? wr_ptr : 0.
  - The value latched is the registered wr_ptr before any increment on that same edge. A simultaneous write therefore shifts the view on the next frame, not the current one.
  - frame_base_adr changes only on vsync rising edges, in all states including FROZEN.
- Arithmetic and widths:
  - max is an unsigned 8-bit compare.
  - Address arithmetic is modulo 2^ADDR_W.
  - dec_cnt is 8 bits.
- DECIMATE=1: every sample_valid commits directly; acc is never used.
- sample_valid held high on consecutive cycles is legal: one write per commit, back-to-back pulses allowed.

Decomposition:
- Shared display package holds:
  - the waveform buffer constants DEPTH/ADDR_W (also used by the display reader);
  - the state encoding localparams FILL=2'd0, RUN=2'd1, FROZEN=2'd2;
  - the sample width constant 8.
- One natural sub-module: peak_decimator (dec_cnt, acc, commit strobe, clear input), instantiated once.
- Edge detect and pointer logic stay in the top module.

Test Plan:
- Reset, DECIMATE=4, samples 10,50,20,30 on 4 strobes -> exactly one bram_we, one cycle after the 4th strobe: adr 0, data 50. wr_ptr=1, fill_level=1.
- DEPTH=8, DECIMATE=1, 10 strobes valued 0..9 -> writes to adr 0..7 then 0,1.
  - wrapped goes high on the adr-7 write; fill_level saturates at 8.
  - Next vsync rise -> frame_base_adr=2.
- Before wrap: 5 writes then vsync rise -> frame_base_adr=0. frame_base_adr is unchanged between vsync edges despite further writes.
- DECIMATE=4, 2 strobes (values 200,100), then freeze=1, then 6 strobes -> no bram_we, frozen=1.
  - freeze=0, then strobes 5,6,7,8 -> one write with data 8 (200 discarded).
- Commit strobe in the same cycle freeze rises -> write still occurs next cycle, then FROZEN. vsync rise coincident with a write -> frame_base_adr equals the pre-increment wr_ptr.
- Assert reset on the cycle after a commit strobe -> no bram_we, all outputs 0, state FILL. After release, the first commit writes adr 0.
